data_ram_arbiter: RTL and testbench
===================================

Name: data_ram_arbiter

Overview:
- Two-requester arbiter that shares the single-port simulation data RAM.
- Requester 0 is the CPU MEM-stage load/store port; requester 1 is a DMA/debug loader port.
- Round-robin arbitration. Each transfer is a single word or byte-lane access with a req/ack handshake.
- Drives the RAM's chip-enable, address, write-enable, byte-select and write-data. Registers RAM read data and returns it to the winning requester.

Parameters:
- DATA_W, 32, data width of the RAM and requester ports
- ADDR_W, 32, byte-address width passed through to the RAM
- SEL_W, 4, byte-lane select width (DATA_W/8)

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, synchronous, active-high
- i_m0_req  input  1  requester 0 access request
- i_m0_addr  input  ADDR_W  requester 0 byte address
- i_m0_we  input  1  requester 0 write (1) / read (0)
- i_m0_sel  input  SEL_W  requester 0 byte-lane select
- i_m0_wdata  input  DATA_W  requester 0 write data
- o_m0_ack  output  1  requester 0 one-cycle completion pulse
- o_m0_rdata  output  DATA_W  requester 0 read data, valid while o_m0_ack=1
- i_m1_req, i_m1_addr, i_m1_we, i_m1_sel, i_m1_wdata, o_m1_ack, o_m1_rdata: same as requester 0, for requester 1
- o_ram_ce  output  1  RAM chip enable
- o_ram_addr  output  ADDR_W  RAM byte address
- o_ram_we  output  1  RAM write enable
- o_ram_sel  output  SEL_W  RAM byte-lane select
- o_ram_wdata  output  DATA_W  RAM write data
- i_ram_rdata  input  DATA_W  RAM combinational read data
- o_busy  output  1  high in any state other than IDLE

Behaviour:
- Interface: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: state=IDLE, last_grant=1, owner=0. All o_ram_* = 0. o_m0_ack = o_m1_ack = 0. o_m0_rdata = o_m1_rdata = 0. o_busy = 0.
- FSM states: IDLE, ACCESS, ACK. Every transition is on the rising edge of i_clk.
- IDLE, no request pending: all o_ram_* = 0; stay in IDLE.
- IDLE, request pending: select a winner, latch owner, register that requester's addr/we/sel/wdata into o_ram_*, set o_ram_ce=1, go to ACCESS.
- Arbitration, both requesting: the winner is the requester not in last_grant. last_grant is updated to the winner.
- Arbitration, one requesting: that requester wins regardless of last_grant. last_grant is still updated.
- ACCESS:
  - o_ram_* hold the registered values for exactly one cycle.
  - Read (o_ram_we=0): i_ram_rdata is captured into the owner's rdata register at the end of the cycle.
  - Write: the RAM commits at the end of this cycle.
  - Next state is ACK. At the transition, o_ram_ce, o_ram_we and o_ram_sel clear to 0; o_ram_addr and o_ram_wdata may hold their values.
- ACK:
  - The owner's o_mX_ack = 1 for exactly one cycle; the other ack stays 0.
  - o_mX_rdata holds the captured word for reads and 0 for writes.
  - Next state is always IDLE. Requests are not sampled in ACK.
- Latency: a request seen in IDLE at cycle t gives o_ram_ce=1 in cycle t+1 and ack in cycle t+2.
- Minimum spacing between transaction starts is 3 cycles.
- o_mX_rdata holds its value until the next transaction completes for that requester.
- Requester contract:
  - Hold req, addr, we, sel and wdata stable until ack.
  - Drop req in the cycle after ack, or keep it high to issue a new request.
  - req still high in the IDLE cycle after ack is a new request.
- Early req drop: the arbiter samples the request only in IDLE. A req dropped after grant does not cancel the transaction; the ack is still issued.
- Simultaneous events: both reqs rising in the same IDLE cycle after reset → requester 0 wins first, then requester 1.
- Fairness: with both requesters continuously requesting, grants strictly alternate.
- Reset mid-operation: state returns to IDLE and all outputs clear on that edge.
  - A write whose ACCESS cycle coincides with i_rst=1 still commits, because the RAM is not reset-gated.
  - No ack is issued for an interrupted transaction.
- Bit widths pass through unmodified. No address translation or alignment check (the RAM ignores addr[1:0]).

Test Plan:
- Reset: hold i_rst=1 for 3 cycles → all outputs 0, o_busy=0. Release with no requests → o_ram_ce stays 0.
- Single read: preload word 0x1000 = 0xDEADBEEF. m0 reads addr 0x1000, sel 4'hF → o_ram_ce=1 one cycle after req, o_m0_ack pulses 2 cycles after req, o_m0_rdata=0xDEADBEEF, o_m1_ack stays 0.
- Byte write then read: m1 writes 0x000000AB, sel 4'b0001, to addr 0x20 over existing 0x11223344 → read back 0x112233AB; o_m1_rdata=0 during the write ack.
- Contention: both reqs high from the same cycle after reset, held for 4 transactions each → grant order m0,m1,m0,m1,… and ack spacing of 3 cycles.
- Reset during ACCESS: m0 writes 0x55 to 0x40 with i_rst asserted in the ACCESS cycle → no o_m0_ack, state=IDLE next cycle, memory at 0x40 = 0x55.
- Early drop: m1 req high for 1 cycle only → transaction still completes and o_m1_ack pulses once; no second grant follows.

Source files
------------

// File: rtl/data_ram_arbiter.sv
// ---------------------------------------------------------------------------
// data_ram_arbiter
//
// Shares one single-port data RAM between two requesters: requester 0 (the
// CPU load/store port) and requester 1 (a DMA/debug loader). Arbitration is
// round-robin. Each transfer is one word or byte-lane access with a req/ack
// handshake: IDLE (grant) -> ACCESS (RAM cycle) -> ACK (one-cycle pulse).
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_mX_req/addr/we/sel/wdata  requester X access request and payload
//   o_mX_ack                requester X one-cycle completion pulse
//   o_mX_rdata              requester X read data (0 after a write)
//   o_ram_ce/addr/we/sel/wdata  registered RAM control and write data
//   i_ram_rdata             combinational RAM read data
//   o_busy                  high in any state other than IDLE
// ---------------------------------------------------------------------------
module data_ram_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int SEL_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_m0_req,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic              i_m0_we,
    input  logic [SEL_W-1:0]  i_m0_sel,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic              o_m0_ack,
    output logic [DATA_W-1:0] o_m0_rdata,

    input  logic              i_m1_req,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic              i_m1_we,
    input  logic [SEL_W-1:0]  i_m1_sel,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_ack,
    output logic [DATA_W-1:0] o_m1_rdata,

    output logic              o_ram_ce,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [SEL_W-1:0]  o_ram_sel,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,

    output logic              o_busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_grant;
    logic              r_owner;
    logic              w_grant;
    logic              w_winner;

    logic              r_ram_ce;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_we;
    logic [SEL_W-1:0]  r_ram_sel;
    logic [DATA_W-1:0] r_ram_wdata;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;

    // Next-state, grant decision and ack outputs.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_winner    = 1'b0;
        o_m0_ack    = 1'b0;
        o_m1_ack    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_m0_req || i_m1_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_ACCESS;
                    // Under contention the requester not served last wins;
                    // a lone requester wins regardless of history.
                    if (i_m0_req && i_m1_req)
                        w_winner = ~r_last_grant;
                    else
                        w_winner = i_m1_req;
                end
            end
            S_ACCESS: w_state_nxt = S_ACK;
            S_ACK: begin
                // Requests are deliberately not sampled here.
                w_state_nxt = S_IDLE;
                o_m0_ack    = ~r_owner;
                o_m1_ack    = r_owner;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Grant bookkeeping, registered RAM interface and read-data capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_ram_ce     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_we     <= 1'b0;
            r_ram_sel    <= '0;
            r_ram_wdata  <= '0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_owner      <= w_winner;
                        r_last_grant <= w_winner;
                        r_ram_ce     <= 1'b1;
                        r_ram_addr   <= w_winner ? i_m1_addr  : i_m0_addr;
                        r_ram_we     <= w_winner ? i_m1_we    : i_m0_we;
                        r_ram_sel    <= w_winner ? i_m1_sel   : i_m0_sel;
                        r_ram_wdata  <= w_winner ? i_m1_wdata : i_m0_wdata;
                    end else begin
                        r_ram_ce     <= 1'b0;
                        r_ram_addr   <= '0;
                        r_ram_we     <= 1'b0;
                        r_ram_sel    <= '0;
                        r_ram_wdata  <= '0;
                    end
                end
                S_ACCESS: begin
                    // Strobes drop after the single RAM cycle; addr/wdata
                    // are left as-is since they are don't-care without ce.
                    r_ram_ce  <= 1'b0;
                    r_ram_we  <= 1'b0;
                    r_ram_sel <= '0;
                    // A write returns 0 so stale read data is never presented
                    // alongside a write ack.
                    if (r_owner)
                        r_m1_rdata <= r_ram_we ? '0 : i_ram_rdata;
                    else
                        r_m0_rdata <= r_ram_we ? '0 : i_ram_rdata;
                end
                default: ;
            endcase
        end
    end

    assign o_ram_ce    = r_ram_ce;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_we    = r_ram_we;
    assign o_ram_sel   = r_ram_sel;
    assign o_ram_wdata = r_ram_wdata;
    assign o_m0_rdata  = r_m0_rdata;
    assign o_m1_rdata  = r_m1_rdata;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_data_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_ram_arbiter
//
// Directed bench for data_ram_arbiter with a small byte-lane RAM model
// (combinational read, clocked write, not reset-gated). Inputs change 1 ns
// after each rising edge and outputs are checked at that same point.
// ---------------------------------------------------------------------------
module tb_data_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we;
    logic [31:0] m0_addr, m0_wdata;
    logic [3:0]  m0_sel;
    logic        m0_ack;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we;
    logic [31:0] m1_addr, m1_wdata;
    logic [3:0]  m1_sel;
    logic        m1_ack;
    logic [31:0] m1_rdata;
    logic        ram_ce, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_sel;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem [0:2047];

    data_ram_arbiter #(.DATA_W(32), .ADDR_W(32), .SEL_W(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_m0_req    (m0_req),
        .i_m0_addr   (m0_addr),
        .i_m0_we     (m0_we),
        .i_m0_sel    (m0_sel),
        .i_m0_wdata  (m0_wdata),
        .o_m0_ack    (m0_ack),
        .o_m0_rdata  (m0_rdata),
        .i_m1_req    (m1_req),
        .i_m1_addr   (m1_addr),
        .i_m1_we     (m1_we),
        .i_m1_sel    (m1_sel),
        .i_m1_wdata  (m1_wdata),
        .o_m1_ack    (m1_ack),
        .o_m1_rdata  (m1_rdata),
        .o_ram_ce    (ram_ce),
        .o_ram_addr  (ram_addr),
        .o_ram_we    (ram_we),
        .o_ram_sel   (ram_sel),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: word-indexed, ignores addr[1:0], writes regardless of reset.
    assign ram_rdata = mem[ram_addr[12:2]];
    always @(posedge clk) begin
        if (ram_ce && ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_sel[b])
                    mem[ram_addr[12:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 1'b0; m0_addr = '0; m0_we = 1'b0; m0_sel = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_addr = '0; m1_we = 1'b0; m1_sel = '0; m1_wdata = '0;
        for (int i = 0; i < 2048; i++) mem[i] <= '0;
        mem[11'h400] <= 32'hDEADBEEF;   // byte addr 0x1000
        mem[11'h008] <= 32'h11223344;   // byte addr 0x20

        // ---- Reset held for 3 cycles ----
        repeat (3) tick();
        check("rst_ce",     {31'b0, ram_ce}, 32'd0);
        check("rst_addr",   ram_addr,        32'd0);
        check("rst_we",     {31'b0, ram_we}, 32'd0);
        check("rst_sel",    {28'b0, ram_sel}, 32'd0);
        check("rst_wdata",  ram_wdata,       32'd0);
        check("rst_ack0",   {31'b0, m0_ack}, 32'd0);
        check("rst_ack1",   {31'b0, m1_ack}, 32'd0);
        check("rst_rdata0", m0_rdata,        32'd0);
        check("rst_rdata1", m1_rdata,        32'd0);
        check("rst_busy",   {31'b0, busy},   32'd0);
        rst = 1'b0;
        tick();
        check("idle_ce_a",  {31'b0, ram_ce}, 32'd0);
        tick();
        check("idle_ce_b",  {31'b0, ram_ce}, 32'd0);
        check("idle_busy",  {31'b0, busy},   32'd0);

        // ---- Single read by m0 ----
        m0_req = 1'b1; m0_addr = 32'h1000; m0_we = 1'b0; m0_sel = 4'hF;
        tick();
        check("rd_ce",      {31'b0, ram_ce}, 32'd1);
        check("rd_addr",    ram_addr,        32'h1000);
        check("rd_we",      {31'b0, ram_we}, 32'd0);
        check("rd_busy",    {31'b0, busy},   32'd1);
        check("rd_ack0_early", {31'b0, m0_ack}, 32'd0);
        tick();
        check("rd_ack0",    {31'b0, m0_ack}, 32'd1);
        check("rd_ack1",    {31'b0, m1_ack}, 32'd0);
        check("rd_rdata0",  m0_rdata,        32'hDEADBEEF);
        check("rd_ce_off",  {31'b0, ram_ce}, 32'd0);
        m0_req = 1'b0;
        tick();
        check("rd_ack0_once", {31'b0, m0_ack}, 32'd0);
        check("rd_rdata0_hold", m0_rdata,    32'hDEADBEEF);
        check("rd_busy_off", {31'b0, busy},  32'd0);

        // ---- Byte-lane write by m1, then read back ----
        m1_req = 1'b1; m1_addr = 32'h20; m1_we = 1'b1; m1_sel = 4'b0001; m1_wdata = 32'h000000AB;
        tick();
        check("bw_ce",      {31'b0, ram_ce}, 32'd1);
        check("bw_we",      {31'b0, ram_we}, 32'd1);
        check("bw_sel",     {28'b0, ram_sel}, 32'h1);
        check("bw_addr",    ram_addr,        32'h20);
        check("bw_wdata",   ram_wdata,       32'hAB);
        tick();
        check("bw_ack1",    {31'b0, m1_ack}, 32'd1);
        check("bw_ack0",    {31'b0, m0_ack}, 32'd0);
        check("bw_rdata1",  m1_rdata,        32'd0);
        check("bw_ram_we_off", {31'b0, ram_we}, 32'd0);
        m1_req = 1'b0;
        tick();
        check("bw_mem",     mem[11'h008],    32'h112233AB);
        m1_req = 1'b1; m1_we = 1'b0; m1_sel = 4'hF; m1_wdata = '0;
        tick();
        tick();
        check("br_ack1",    {31'b0, m1_ack}, 32'd1);
        check("br_rdata1",  m1_rdata,        32'h112233AB);
        m1_req = 1'b0;
        tick();

        // ---- Contention right after reset: strict alternation, 3-cycle spacing ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_req = 1'b1; m0_addr = 32'h1000; m0_we = 1'b0; m0_sel = 4'hF;
        m1_req = 1'b1; m1_addr = 32'h20;   m1_we = 1'b0; m1_sel = 4'hF;
        for (int k = 0; k < 8; k++) begin
            logic owner;
            owner = k[0];
            tick();
            check($sformatf("ct%0d_ce", k),   {31'b0, ram_ce}, 32'd1);
            check($sformatf("ct%0d_addr", k), ram_addr, owner ? 32'h20 : 32'h1000);
            check($sformatf("ct%0d_noack", k), {30'b0, m1_ack, m0_ack}, 32'd0);
            tick();
            check($sformatf("ct%0d_acks", k), {30'b0, m1_ack, m0_ack}, owner ? 32'd2 : 32'd1);
            if (owner)
                check($sformatf("ct%0d_rdata1", k), m1_rdata, 32'h112233AB);
            else
                check($sformatf("ct%0d_rdata0", k), m0_rdata, 32'hDEADBEEF);
            tick();
            check($sformatf("ct%0d_idle", k), {29'b0, busy, m1_ack, m0_ack}, 32'd0);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
        check("ct_end_ce",  {31'b0, ram_ce}, 32'd0);

        // ---- Reset coinciding with a write's ACCESS cycle ----
        m0_req = 1'b1; m0_addr = 32'h40; m0_we = 1'b1; m0_sel = 4'hF; m0_wdata = 32'h55;
        tick();
        check("rw_ce",      {31'b0, ram_ce}, 32'd1);
        check("rw_we",      {31'b0, ram_we}, 32'd1);
        rst = 1'b1;
        m0_req = 1'b0;
        tick();
        rst = 1'b0;
        check("rw_busy",    {31'b0, busy},   32'd0);
        check("rw_ce_off",  {31'b0, ram_ce}, 32'd0);
        check("rw_ack0",    {31'b0, m0_ack}, 32'd0);
        check("rw_rdata0",  m0_rdata,        32'd0);
        check("rw_mem",     mem[11'h010],    32'h55);
        tick();
        check("rw_ack0_late", {31'b0, m0_ack}, 32'd0);
        check("rw_busy_late", {31'b0, busy},   32'd0);

        // ---- Early req drop by m1: transaction still completes once ----
        m1_req = 1'b1; m1_addr = 32'h1000; m1_we = 1'b0; m1_sel = 4'hF;
        tick();
        m1_req = 1'b0;
        check("ed_ce",      {31'b0, ram_ce}, 32'd1);
        tick();
        check("ed_ack1",    {31'b0, m1_ack}, 32'd1);
        check("ed_rdata1",  m1_rdata,        32'hDEADBEEF);
        tick();
        check("ed_ack1_once", {31'b0, m1_ack}, 32'd0);
        tick();
        check("ed_no_regrant", {31'b0, ram_ce}, 32'd0);
        check("ed_busy",    {31'b0, busy},   32'd0);
        check("ed_ack1_none", {31'b0, m1_ack}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
